irq_sched: RTL and testbench



---
 rtl/irq_sched.sv | 130 +++++++++++++
 tb/tb_irq_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_sched.sv
// Raster-timed interrupt scheduler: raises RST 1 (mid-screen) and RST 2 (vblank)
// requests and answers the i8080 INTA handshake with the matching RST opcode.
`ifndef STATUS_INTA
`define STATUS_INTA 0
`endif

module irq_sched #(
  parameter int unsigned LINE_CLKS       = 4,
  parameter int unsigned LINES_PER_FRAME = 262,
  parameter int unsigned MID_LINE        = 96,
  parameter int unsigned VBLANK_LINE     = 224,
  parameter int unsigned XLEN            = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sync,
  input  logic            dbin,
  input  logic [XLEN-1:0] status_in,
  output logic            iint,
  output logic [XLEN-1:0] data_out,
  output logic            data_oe,
  output logic [8:0]      line,
  output logic            frame_tick,
  output logic [1:0]      pending
);

  localparam int unsigned PIX_W = (LINE_CLKS > 1) ? $clog2(LINE_CLKS) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(LINE_CLKS - 1);
  localparam logic [8:0]       LINE_LAST = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0]       LINE_MID  = 9'(MID_LINE);
  localparam logic [8:0]       LINE_VBL  = 9'(VBLANK_LINE);
  localparam logic [XLEN-1:0]  VEC_RST1  = XLEN'(8'hCF);
  localparam logic [XLEN-1:0]  VEC_RST2  = XLEN'(8'hD7);
  localparam logic [XLEN-1:0]  VEC_RST7  = XLEN'(8'hFF);

  typedef enum logic [1:0] {IDLE, ARMED, DRIVE} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_MID, SRC_VBL} src_t;

  state_t           state;
  src_t             src;
  logic [XLEN-1:0]  vector;
  logic [PIX_W-1:0] pix_cnt;
  logic             mid_pend, vbl_pend;
  logic             inta, abort, ack_done;
  logic             mid_evt, vbl_evt, mid_clr, vbl_clr;
  logic             unused_status;

  always_comb begin
    inta          = sync && status_in[`STATUS_INTA];
    abort         = sync && !status_in[`STATUS_INTA];
    unused_status = ^status_in;
    mid_evt       = (line == LINE_MID) && (pix_cnt == '0);
    vbl_evt       = (line == LINE_VBL) && (pix_cnt == '0);
    // A foreign status word ends the handshake without acknowledging anything.
    ack_done      = (state == DRIVE) && !abort && !dbin;
    mid_clr       = ack_done && (src == SRC_MID);
    vbl_clr       = ack_done && (src == SRC_VBL);
  end

  assign pending = {vbl_pend, mid_pend};

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt    <= '0;
      line       <= '0;
      frame_tick <= 1'b0;
      mid_pend   <= 1'b0;
      vbl_pend   <= 1'b0;
      iint       <= 1'b0;
      data_oe    <= 1'b0;
      data_out   <= '0;
      vector     <= '0;
      src        <= SRC_NONE;
      state      <= IDLE;
    end else begin
      if (pix_cnt == PIX_LAST) begin
        pix_cnt <= '0;
        line    <= (line == LINE_LAST) ? '0 : line + 9'd1;
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
      end
      frame_tick <= (line == '0) && (pix_cnt == '0);

      // Set is ORed in after the clear so a coincident new event is never lost.
      mid_pend <= mid_evt | (mid_pend & ~mid_clr);
      vbl_pend <= vbl_evt | (vbl_pend & ~vbl_clr);
      iint     <= mid_pend | vbl_pend;

      case (state)
        IDLE: begin
          data_oe <= 1'b0;
          if (inta) begin
            state <= ARMED;
            if (vbl_pend) begin
              vector <= VEC_RST2;
              src    <= SRC_VBL;
            end else if (mid_pend) begin
              vector <= VEC_RST1;
              src    <= SRC_MID;
            end else begin
              vector <= VEC_RST7;
              src    <= SRC_NONE;
            end
          end
        end
        ARMED: begin
          if (abort) begin
            state   <= IDLE;
            data_oe <= 1'b0;
          end else if (dbin) begin
            state    <= DRIVE;
            data_oe  <= 1'b1;
            data_out <= vector;
          end
        end
        DRIVE: begin
          if (abort || !dbin) begin
            state   <= IDLE;
            data_oe <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          data_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched: raster timing, INTA handshakes, priority,
// spurious acks, aborts, set/clear race and reset during the drive window.
module tb_irq_sched;

  localparam int unsigned XLEN = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sync = 1'b0;
  logic            dbin = 1'b0;
  logic [XLEN-1:0] status_in = '0;
  logic            iint;
  logic [XLEN-1:0] data_out;
  logic            data_oe;
  logic [8:0]      line;
  logic            frame_tick;
  logic [1:0]      pending;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [XLEN-1:0] vec_q[$];
  logic [9:0]      tim_q[$];
  logic            oe_prev = 1'b0;

  irq_sched #(
    .LINE_CLKS(2),
    .LINES_PER_FRAME(8),
    .MID_LINE(2),
    .VBLANK_LINE(6),
    .XLEN(XLEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sync(sync),
    .dbin(dbin),
    .status_in(status_in),
    .iint(iint),
    .data_out(data_out),
    .data_oe(data_oe),
    .line(line),
    .frame_tick(frame_tick),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sync = 1'b0;
    dbin = 1'b0;
    status_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Full INTA handshake; nhold extra DBIN cycles keep the driver in DRIVE.
  task automatic ack(input logic [XLEN-1:0] vec, input int unsigned nhold, input string tag);
    vec_q.push_back(vec);
    sync = 1'b1;
    status_in = 8'h23;
    tick();
    check({tag, "_armed_oe"}, 32'(data_oe), 32'd0);
    sync = 1'b0;
    status_in = '0;
    dbin = 1'b1;
    tick();
    check({tag, "_drive_oe"}, 32'(data_oe), 32'd1);
    for (int unsigned i = 0; i < nhold; i++) begin
      tick();
      check({tag, "_hold_oe"}, 32'(data_oe), 32'd1);
    end
    dbin = 1'b0;
    tick();
    check({tag, "_release_oe"}, 32'(data_oe), 32'd0);
  endtask

  // Scoreboard: every rising data_oe must match the oldest outstanding ack vector.
  always @(negedge clk) begin
    if (data_oe && !oe_prev) begin
      compared++;
      assert (vec_q.size() > 0) else begin
        mismatched++;
        $error("FAIL drive_queued: observed data_oe=1 data_out=%0h, required no drive", data_out);
      end
      if (vec_q.size() > 0) check("vector", 32'(data_out), 32'(vec_q.pop_front()));
    end
    oe_prev = data_oe;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_t;

    do_reset();
    check("rst_line", 32'(line), 32'd0);
    check("rst_iint", 32'(iint), 32'd0);
    check("rst_oe", 32'(data_oe), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_ftick", 32'(frame_tick), 32'd0);

    for (int k = 1; k <= 17; k++) begin
      tim_q.push_back({9'((k / 2) % 8), (k % 16) == 1});
      tick();
      exp_t = tim_q.pop_front();
      check("line_ftick", {22'd0, line, frame_tick}, 32'(exp_t));
    end

    do_reset();
    run_to(5);
    check("mid_pend_set", 32'(pending), 32'd1);
    check("mid_iint_lag", 32'(iint), 32'd0);
    tick();
    check("mid_iint", 32'(iint), 32'd1);
    ack(8'hCF, 1, "mid");
    check("mid_cleared", 32'(pending), 32'd0);
    tick();
    check("mid_iint_low", 32'(iint), 32'd0);

    do_reset();
    run_to(14);
    check("both_pend", 32'(pending), 32'd3);
    ack(8'hD7, 1, "prio_vbl");
    check("prio_after_vbl", 32'(pending), 32'd1);
    check("prio_iint_a", 32'(iint), 32'd1);
    ack(8'hCF, 1, "prio_mid");
    check("prio_after_mid", 32'(pending), 32'd0);

    do_reset();
    ack(8'hFF, 1, "spur");
    check("spur_pending", 32'(pending), 32'd0);

    do_reset();
    run_to(6);
    sync = 1'b1;
    status_in = 8'h23;
    tick();
    status_in = 8'h82;
    tick();
    sync = 1'b0;
    status_in = '0;
    dbin = 1'b1;
    tick();
    check("abort_oe_a", 32'(data_oe), 32'd0);
    tick();
    check("abort_oe_b", 32'(data_oe), 32'd0);
    dbin = 1'b0;
    tick();
    check("abort_pending", 32'(pending), 32'd1);

    do_reset();
    run_to(6);
    ack(8'hCF, 12, "race");
    check("race_cyc", 32'(cyc), 32'd21);
    check("race_pending", 32'(pending), 32'd3);
    tick();
    check("race_iint", 32'(iint), 32'd1);

    do_reset();
    run_to(6);
    vec_q.push_back(8'hCF);
    sync = 1'b1;
    status_in = 8'h23;
    tick();
    sync = 1'b0;
    status_in = '0;
    dbin = 1'b1;
    tick();
    check("rstdrv_oe_on", 32'(data_oe), 32'd1);
    rst = 1'b1;
    tick();
    check("rstdrv_oe", 32'(data_oe), 32'd0);
    check("rstdrv_pending", 32'(pending), 32'd0);
    check("rstdrv_line", 32'(line), 32'd0);
    check("rstdrv_iint", 32'(iint), 32'd0);
    rst = 1'b0;
    dbin = 1'b0;
    tick();
    tick();

    check("vec_q_drained", 32'(vec_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
